// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: IF fetch port, MEM data port,
// external memory command/response port, stall and watchdog error.
//
// Handshake semantics: a requester raises *_req_i with stable command fields and
// holds it until it sees its one-cycle *_ack_o. *_rdata_o is valid in the ack
// cycle and holds afterwards. The arbiter holds mem_req_o and the mem_* command
// stable until mem_ack_i, which is sampled only while mem_req_o is high.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_flush_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_ack_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;
  logic              stall_o;
  logic              timeout_err_o;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i, if_flush_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           mem_rdata_i, mem_ack_i,
    output if_rdata_o, if_ack_o, d_rdata_o, d_ack_o, mem_req_o, mem_we_o,
           mem_addr_o, mem_wdata_o, stall_o, timeout_err_o
  );

  // Pipeline / memory environment side
  modport master (
    output if_req_i, if_addr_i, if_flush_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
           mem_rdata_i, mem_ack_i,
    input  if_rdata_o, if_ack_o, d_rdata_o, d_ack_o, mem_req_o, mem_we_o,
           mem_addr_o, mem_wdata_o, stall_o, timeout_err_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port variable-latency memory between the
// instruction fetch (IF) and data (MEM) stages. Round-robin on contention,
// registered memory command, one-cycle acks, combinational pipeline stall.
// Optional watchdog on the memory response: define ARB_TIMEOUT_EN.
// state_o exposes the FSM state: 0 IDLE, 1 GNT_IF, 2 GNT_D, 3 RESP.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.slave  bus,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2,
    RESP   = 2'd3
  } state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT must be at least 1");
  end

  state_t            state_q, state_d;
  logic              last_gnt_d_q;   // 1 when D won the most recent grant
  logic              drop_q;         // in-flight fetch was flushed
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              if_ack_q, d_ack_q;
  logic              if_pend;
  logic              grant_if, grant_d;
  logic              mem_done, wd_fire, timeout_hit;

  // A flushed fetch is not a candidate for the port this cycle.
  assign if_pend = bus.if_req_i & ~bus.if_flush_i;

  // Next-state logic: arbitration in IDLE, completion or expiry in GNT_*.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    mem_done = 1'b0;
    wd_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the requester that did not win last time goes first.
        grant_d  = bus.d_req_i & (~if_pend | ~last_gnt_d_q);
        grant_if = if_pend & (~bus.d_req_i | last_gnt_d_q);
        if (grant_d)       state_d = GNT_D;
        else if (grant_if) state_d = GNT_IF;
      end
      GNT_IF, GNT_D: begin
        mem_done = bus.mem_ack_i & mem_req_q;
        // A response arriving with the expiry wins over the watchdog.
        wd_fire  = timeout_hit & ~mem_done;
        if (mem_done || wd_fire) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, memory command registers, acks and read-data capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_gnt_d_q <= 1'b0;
      drop_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      if (grant_if || grant_d) begin
        mem_req_q    <= 1'b1;
        mem_we_q     <= grant_d & bus.d_we_i;
        mem_addr_q   <= grant_d ? bus.d_addr_i : bus.if_addr_i;
        last_gnt_d_q <= grant_d;
        if (grant_d) mem_wdata_q <= bus.d_wdata_i;
      end
      if (state_q == RESP)
        drop_q <= 1'b0;
      else if (state_q == GNT_IF && bus.if_flush_i)
        drop_q <= 1'b1;
      if (mem_done || wd_fire) begin
        mem_req_q <= 1'b0;
        if (state_q == GNT_IF) begin
          // A flush seen before or with the response silently discards it.
          if (!(drop_q || bus.if_flush_i)) begin
            if_ack_q   <= 1'b1;
            if_rdata_q <= mem_done ? bus.mem_rdata_i : '0;
          end
        end else begin
          d_ack_q <= 1'b1;
          if (!mem_done)      d_rdata_q <= '0;
          else if (!mem_we_q) d_rdata_q <= bus.mem_rdata_i;
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             timeout_err_q;

  // Expires in the TIMEOUT-th cycle spent waiting in GNT_*.
  assign timeout_hit = (wd_cnt_q == CNT_W'(TIMEOUT - 1));

  // Watchdog counter restarts on every grant; the error flag is sticky until reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (grant_if || grant_d)
        wd_cnt_q <= '0;
      else if (state_q == GNT_IF || state_q == GNT_D)
        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
      if (wd_fire) timeout_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err_o = timeout_err_q;
`else
  assign timeout_hit       = 1'b0;
  assign bus.timeout_err_o = 1'b0;
`endif

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.d_rdata_o   = d_rdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.d_ack_o     = d_ack_q;
  assign bus.stall_o     = (bus.d_req_i & ~d_ack_q) |
                           (bus.if_req_i & ~if_ack_q & ~bus.if_flush_i);
  assign state_o         = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized
// request/latency mix checked against a transaction-level model
// (round-robin winner, unified memory contents, expected read data).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dut_state;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .bus     (bus),
    .state_o (dut_state)
  );

  // ---------------- scoreboard / model state ----------------
  int              vectors = 0;
  int              miscompares = 0;
  logic [DW-1:0]   exp_q[$];
  logic [DW-1:0]   mem_m [logic [AW-1:0]];
  logic [DW-1:0]   exp_if_rdata = '0;
  logic [DW-1:0]   exp_d_rdata = '0;
  bit              last_d = 1'b0;   // model: D won the previous grant
  bit              exp_terr = 1'b0;
  bit              p_if = 1'b0, p_d = 1'b0, we = 1'b0;
  logic [AW-1:0]   a_if = '0, a_d = '0;
  logic [DW-1:0]   wd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] addr);
    if (mem_m.exists(addr)) return mem_m[addr];
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    bus.if_req_i  = p_if;
    bus.if_addr_i = a_if;
    bus.d_req_i   = p_d;
    bus.d_we_i    = we;
    bus.d_addr_i  = a_d;
    bus.d_wdata_i = wd;
  endtask

  // One complete access starting from an IDLE cycle; memory answers after lat wait cycles.
  task automatic round(input int lat);
    bit            win_d;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd;
    drive_reqs();
    win_d  = p_d && !(p_if && last_d);
    last_d = win_d;
    addr   = win_d ? a_d : a_if;
    rd     = mem_read(addr);
    tick();
    chk("grant_we", bus.mem_we_o, 32'(win_d && we));
    if (win_d && we) chk("grant_wdata", bus.mem_wdata_o, wd);
    chk("stall_busy", bus.stall_o, 1);
    for (int k = 0; k <= lat; k++) begin
      chk("hold_req", bus.mem_req_o, 1);
      chk("hold_addr", bus.mem_addr_o, addr);
      bus.mem_ack_i   = (k == lat);
      bus.mem_rdata_i = (k == lat) ? rd : $urandom;
      tick();
    end
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = $urandom;
    if (win_d) begin
      if (we) mem_m[addr] = wd;
      else    exp_d_rdata = rd;
      exp_q.push_back(exp_d_rdata);
    end else begin
      exp_if_rdata = rd;
      exp_q.push_back(exp_if_rdata);
    end
    chk("resp_if_ack", bus.if_ack_o, 32'(!win_d));
    chk("resp_d_ack", bus.d_ack_o, 32'(win_d));
    chk("resp_req_low", bus.mem_req_o, 0);
    chk("resp_stall", bus.stall_o, 32'(win_d ? p_if : p_d));
    chk("resp_terr", bus.timeout_err_o, 32'(exp_terr));
    if (win_d) begin
      chk("resp_d_rdata", bus.d_rdata_o, exp_q.pop_front());
      chk("keep_if_rdata", bus.if_rdata_o, exp_if_rdata);
      p_d = 1'b0;
    end else begin
      chk("resp_if_rdata", bus.if_rdata_o, exp_q.pop_front());
      chk("keep_d_rdata", bus.d_rdata_o, exp_d_rdata);
      p_if = 1'b0;
    end
    // Winner still holds req through RESP: it must not be re-granted.
    tick();
    chk("no_regrant", bus.mem_req_o, 0);
    chk("idle_acks", {30'd0, bus.if_ack_o, bus.d_ack_o}, 0);
    drive_reqs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    bus.if_req_i = 0; bus.if_addr_i = '0; bus.if_flush_i = 0;
    bus.d_req_i = 0; bus.d_we_i = 0; bus.d_addr_i = '0; bus.d_wdata_i = '0;
    bus.mem_rdata_i = '0; bus.mem_ack_i = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_mem_cmd", bus.mem_addr_o | bus.mem_wdata_o | 32'(bus.mem_we_o), 0);
    chk("rst_rdata", bus.if_rdata_o | bus.d_rdata_o, 0);
    chk("rst_acks", {29'd0, bus.if_ack_o, bus.d_ack_o, bus.timeout_err_o}, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_state", dut_state, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("idle_mem_req", bus.mem_req_o, 0);

    // Contention: both held, latency 2, D first after reset then alternate
    p_if = 1; a_if = 32'h100; p_d = 1; we = 0; a_d = 32'h200; wd = '0;
    for (int i = 0; i < 4; i++) begin
      if (!p_if) begin p_if = 1; a_if = 32'h100 + 32'(i * 4); end
      if (!p_d)  begin p_d = 1; a_d = 32'h200 + 32'(i * 4); end
      round(2);
    end
    repeat (2) if (p_if || p_d) round(2);

    // Single fetch, zero-wait memory
    mem_m[32'h10] = 32'h8C02_0004;
    p_if = 1; a_if = 32'h10;
    round(0);

    // Store
    p_d = 1; we = 1; a_d = 32'h20; wd = 32'hDEAD_BEEF;
    round(1);
    we = 0;

    // Flush while a fetch is in flight (latency 4, flush in 2nd GNT cycle)
    p_if = 1; a_if = 32'h40;
    drive_reqs();
    last_d = 0;
    tick();
    chk("flush_gnt_addr", bus.mem_addr_o, 32'h40);
    tick();
    bus.if_flush_i = 1; bus.if_req_i = 0; p_if = 0;
    #1;
    chk("flush_stall", bus.stall_o, 0);
    tick();
    bus.if_flush_i = 0;
    repeat (2) tick();
    chk("flush_req_held", bus.mem_req_o, 1);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hBAD0_F00D;
    tick();
    bus.mem_ack_i = 0;
    chk("flush_no_ack", bus.if_ack_o, 0);
    chk("flush_rdata_kept", bus.if_rdata_o, exp_if_rdata);
    chk("flush_req_low", bus.mem_req_o, 0);
    tick();
    p_if = 1; a_if = 32'h44;
    round(1);

    // Randomized request mix and memory latency
    for (int r = 0; r < 40; r++) begin
      if (!p_if) begin p_if = 1'($urandom_range(0, 1)); a_if = {24'd0, 6'($urandom_range(0, 63)), 2'b00}; end
      if (!p_d) begin
        p_d = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
        a_d = {24'd0, 6'($urandom_range(0, 63)), 2'b00}; wd = $urandom;
      end
      if (!p_if && !p_d) p_d = 1;
      round($urandom_range(0, 3));
    end
    repeat (2) if (p_if || p_d) round(0);

    // Reset in the middle of a data access
    p_d = 1; we = 0; a_d = 32'h80;
    drive_reqs();
    tick();
    chk("midrst_gnt", bus.mem_req_o, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_async", bus.mem_req_o, 0);
    chk("midrst_rdata", bus.if_rdata_o | bus.d_rdata_o, 0);
    exp_if_rdata = '0; exp_d_rdata = '0; last_d = 0; exp_terr = 0;
    p_d = 0; bus.d_req_i = 0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h1234_5678;
    tick();
    bus.mem_ack_i = 0;
    chk("late_ack_d", bus.d_ack_o, 0);
    chk("late_ack_req", bus.mem_req_o, 0);
    tick();
    chk("late_ack_d_after", {30'd0, bus.if_ack_o, bus.d_ack_o}, 0);
    chk("late_ack_rdata", bus.d_rdata_o, 0);

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: watchdog completes the load with zero data
    p_d = 1; we = 0; a_d = 32'hC0;
    drive_reqs();
    last_d = 1;
    tick();
    cnt = 0;
    while (bus.mem_req_o === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("wd_gnt_cycles", 32'(cnt), 15);
    chk("wd_d_ack", bus.d_ack_o, 1);
    chk("wd_rdata_zero", bus.d_rdata_o, 0);
    chk("wd_err_set", bus.timeout_err_o, 1);
    exp_d_rdata = '0; exp_terr = 1;
    p_d = 0; bus.d_req_i = 0;
    tick();
    chk("wd_err_sticky", bus.timeout_err_o, 1);
    p_if = 1; a_if = 32'h50;
    round(0);
`else
    cnt = 0;
    chk("no_wd_err", bus.timeout_err_o, 32'(cnt));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL tb_timeout: observed no completion, expected finish before 200000");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
